// File: rtl/add16_arbiter.sv
// add16_arbiter: shares one 16-bit carry look-ahead adder between NREQ
// requesters. Narrow (16-bit) adds finish in one pass. Wide (32-bit) adds use
// a second pass in state HI that adds the captured high halves plus the
// stored low carry. Results are registered and tagged with the requester
// index.
// Build option: define ADD16_ARB_RR_EN for round-robin arbitration. When it
// is left undefined, the lowest requester index always wins.

// CLA16B4x4S: four 4-bit look-ahead groups joined by a second look-ahead
// level across the groups.
module CLA16B4x4S (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ci,
  output logic [15:0] s,
  output logic        co
);
  // Carries into bits 1..3 of a 4-bit group, from bit generate/propagate
  function automatic logic [2:0] carry3(input logic [2:0] g, input logic [2:0] p,
                                        input logic c0);
    logic [2:0] c;
    c[0] = g[0] | (p[0] & c0);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

  // Group generate: carry out of a 4-bit group when its carry-in is 0
  function automatic logic grp_gen(input logic [3:0] g, input logic [3:1] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [15:0] w_c;
  logic [3:0]  w_gg;
  logic [3:0]  w_gp;
  logic [3:0]  w_gcin;

  assign w_g = a & b;
  assign w_p = a ^ b;

  for (genvar j = 0; j < 4; j++) begin : g_grp
    assign w_gg[j]            = grp_gen(w_g[4*j +: 4], w_p[4*j+1 +: 3]);
    assign w_gp[j]            = &w_p[4*j +: 4];
    assign w_c[4*j]           = w_gcin[j];
    assign w_c[4*j+1 +: 3]    = carry3(w_g[4*j +: 3], w_p[4*j +: 3], w_gcin[j]);
  end

  // The second look-ahead level uses the same equations on group generate and propagate.
  assign w_gcin[0]   = ci;
  assign w_gcin[3:1] = carry3(w_gg[2:0], w_gp[2:0], ci);
  assign co          = grp_gen(w_gg, w_gp[3:1]) | ((&w_gp) & ci);
  assign s           = w_p ^ w_c;
endmodule

module add16_arbiter #(
  parameter int NREQ = 3,
  parameter int IDW  = 2
) (
  input  logic                 cp2,
  input  logic                 ireset,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ-1:0]      wide_i,
  input  logic [NREQ*32-1:0]   a_i,
  input  logic [NREQ*32-1:0]   b_i,
  input  logic [NREQ-1:0]      ci_i,
  output logic [NREQ-1:0]      gnt_o,
  output logic [31:0]          res_o,
  output logic                 co_o,
  output logic                 res_vld_o,
  output logic [IDW-1:0]       res_id_o,
  output logic                 busy_o
);
  typedef enum logic {S_IDLE = 1'b0, S_HI = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [IDW-1:0]   w_base;
  logic [IDW:0]     w_sidx;
  logic             w_hit;
  logic             w_found;
  logic [IDW-1:0]   w_win;

  logic [NREQ-1:0]  w_onehot;
  logic [15:0]      w_lo_a;
  logic [15:0]      w_lo_b;
  logic [15:0]      w_sel_hi_a;
  logic [15:0]      w_sel_hi_b;
  logic             w_sel_ci;
  logic             w_sel_wide;

  logic [NREQ-1:0]  w_gnt;
  logic [15:0]      w_add_a;
  logic [15:0]      w_add_b;
  logic             w_add_ci;
  logic [15:0]      w_sum;
  logic             w_co;

  logic [31:0]      r_res;
  logic             r_co;
  logic             r_vld;
  logic [IDW-1:0]   r_id;
  logic [15:0]      r_hi_a;
  logic [15:0]      r_hi_b;
  logic             r_lo_c;

`ifdef ADD16_ARB_RR_EN
  logic [IDW-1:0]   r_ptr;

  // The round-robin pointer holds last winner + 1 modulo NREQ. It moves only when a grant is issued.
  always_ff @(posedge cp2 or posedge ireset) begin
    if (ireset) begin
      r_ptr <= '0;
    end else if (r_state == S_IDLE && w_found) begin
      r_ptr <= (w_win == IDW'(NREQ - 1)) ? '0 : w_win + IDW'(1);
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign w_base = r_ptr;
`else
  assign w_base = '0;
`endif

  // Search the requests starting at w_base and wrapping around; the first hit wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sidx  = '0;
    w_hit   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      w_sidx  = {1'b0, w_base} + (IDW+1)'(k);
      w_sidx  = (w_sidx >= (IDW+1)'(NREQ)) ? w_sidx - (IDW+1)'(NREQ) : w_sidx;
      w_hit   = req_i[w_sidx[IDW-1:0]] & ~w_found;
      w_win   = w_hit ? w_sidx[IDW-1:0] : w_win;
      w_found = w_found | w_hit;
    end
  end

  // Operand and flag select for the winning requester
  always_comb begin
    w_onehot   = '0;
    w_lo_a     = '0;
    w_lo_b     = '0;
    w_sel_hi_a = '0;
    w_sel_hi_b = '0;
    w_sel_ci   = 1'b0;
    w_sel_wide = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      w_onehot[i] = (w_win == IDW'(i));
      w_lo_a      = w_onehot[i] ? a_i[i*32 +: 16]      : w_lo_a;
      w_lo_b      = w_onehot[i] ? b_i[i*32 +: 16]      : w_lo_b;
      w_sel_hi_a  = w_onehot[i] ? a_i[i*32 + 16 +: 16] : w_sel_hi_a;
      w_sel_hi_b  = w_onehot[i] ? b_i[i*32 + 16 +: 16] : w_sel_hi_b;
      w_sel_ci    = w_onehot[i] ? ci_i[i]              : w_sel_ci;
      w_sel_wide  = w_onehot[i] ? wide_i[i]            : w_sel_wide;
    end
  end

  // FSM state register
  always_ff @(posedge cp2 or posedge ireset) begin
    if (ireset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state, grant, and adder input mux
  always_comb begin
    w_state_nxt = r_state;
    w_gnt       = '0;
    w_add_a     = '0;
    w_add_b     = '0;
    w_add_ci    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_add_a  = w_lo_a;
        w_add_b  = w_lo_b;
        w_add_ci = w_sel_ci;
        if (w_found) begin
          w_gnt       = w_onehot;
          w_state_nxt = w_sel_wide ? S_HI : S_IDLE;
        end else begin
          w_gnt       = '0;
          w_state_nxt = S_IDLE;
        end
      end
      S_HI: begin
        w_add_a     = r_hi_a;
        w_add_b     = r_hi_b;
        w_add_ci    = r_lo_c;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  CLA16B4x4S u_cla (
    .a  (w_add_a),
    .b  (w_add_b),
    .ci (w_add_ci),
    .s  (w_sum),
    .co (w_co)
  );

  // Result, tag and high-half capture registers. res_vld_o is a one-cycle pulse.
  always_ff @(posedge cp2 or posedge ireset) begin
    if (ireset) begin
      r_res  <= 32'h0000_0000;
      r_co   <= 1'b0;
      r_vld  <= 1'b0;
      r_id   <= '0;
      r_hi_a <= 16'h0000;
      r_hi_b <= 16'h0000;
      r_lo_c <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_res[15:0] <= w_sum;
            r_co        <= w_co;
            r_id        <= w_win;
            if (w_sel_wide) begin
              r_hi_a <= w_sel_hi_a;
              r_hi_b <= w_sel_hi_b;
              r_lo_c <= w_co;
            end else begin
              r_res[31:16] <= 16'h0000;
              r_vld        <= 1'b1;
            end
          end else begin
            r_vld <= 1'b0;
          end
        end
        S_HI: begin
          r_res[31:16] <= w_sum;
          r_co         <= w_co;
          r_vld        <= 1'b1;
        end
        default: begin
          r_vld <= 1'b0;
        end
      endcase
    end
  end

  // Force the grant low while reset is asserted, so no request is acknowledged during reset.
  assign gnt_o     = w_gnt & {NREQ{~ireset}};
  assign res_o     = r_res;
  assign co_o      = r_co;
  assign res_vld_o = r_vld;
  assign res_id_o  = r_id;
  assign busy_o    = (r_state == S_HI);
endmodule

// File: tb/tb_add16_arbiter.sv
// Testbench for add16_arbiter. It checks directed cases and then random
// traffic against a reference model built from whole-word arithmetic.
module tb_add16_arbiter;
  localparam int NREQ = 3;
  localparam int IDW  = 2;

  logic                cp2 = 1'b0;
  logic                ireset = 1'b1;
  logic [NREQ-1:0]     req_i = '0;
  logic [NREQ-1:0]     wide_i = '0;
  logic [NREQ*32-1:0]  a_i = '0;
  logic [NREQ*32-1:0]  b_i = '0;
  logic [NREQ-1:0]     ci_i = '0;
  logic [NREQ-1:0]     gnt_o;
  logic [31:0]         res_o;
  logic                co_o;
  logic                res_vld_o;
  logic [IDW-1:0]      res_id_o;
  logic                busy_o;

  add16_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .cp2       (cp2),
    .ireset    (ireset),
    .req_i     (req_i),
    .wide_i    (wide_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .ci_i      (ci_i),
    .gnt_o     (gnt_o),
    .res_o     (res_o),
    .co_o      (co_o),
    .res_vld_o (res_vld_o),
    .res_id_o  (res_id_o),
    .busy_o    (busy_o)
  );

  always #5 cp2 = ~cp2;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit              m_hi;
  logic [31:0]     m_res;
  logic            m_co;
  logic            m_vld;
  int              m_id;
  int              m_ptr;
  logic [32:0]     m_pend;
  logic [NREQ-1:0] m_gnt;
  logic [NREQ-1:0] obs_gnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] rq, input int base);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (base + k) % NREQ;
      if (rq[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_hi  = 1'b0;
    m_res = 32'h0;
    m_co  = 1'b0;
    m_vld = 1'b0;
    m_id  = 0;
    m_ptr = 0;
    m_gnt = '0;
  endtask

  // Compute the expected grant for the current inputs, then the state after the next clock edge.
  task automatic model_edge();
    logic [31:0] aw, bw;
    logic [16:0] lo;
    int w;
    m_gnt = '0;
    if (m_hi) begin
      m_res[31:16] = m_pend[31:16];
      m_co         = m_pend[32];
      m_vld        = 1'b1;
      m_hi         = 1'b0;
    end else begin
`ifdef ADD16_ARB_RR_EN
      w = pick(req_i, m_ptr);
`else
      w = pick(req_i, 0);
`endif
      if (w < 0) begin
        m_vld = 1'b0;
      end else begin
        m_gnt = NREQ'(1) << w;
        m_id  = w;
        m_ptr = (w + 1) % NREQ;
        aw    = 32'(a_i >> (32 * w));
        bw    = 32'(b_i >> (32 * w));
        lo    = {1'b0, aw[15:0]} + {1'b0, bw[15:0]} + 17'(ci_i[w]);
        if (wide_i[w]) begin
          m_pend      = {1'b0, aw} + {1'b0, bw} + 33'(ci_i[w]);
          m_res[15:0] = lo[15:0];
          m_co        = lo[16];
          m_vld       = 1'b0;
          m_hi        = 1'b1;
        end else begin
          m_res = {16'h0000, lo[15:0]};
          m_co  = lo[16];
          m_vld = 1'b1;
        end
      end
    end
  endtask

  // Entered one time unit after a rising edge: drive inputs, check the grant, advance one clock, check the outputs.
  task automatic step(input logic [NREQ-1:0] rq, input logic [NREQ-1:0] wd,
                      input logic [NREQ-1:0] cv, input logic [NREQ*32-1:0] av,
                      input logic [NREQ*32-1:0] bv);
    req_i  = rq;
    wide_i = wd;
    ci_i   = cv;
    a_i    = av;
    b_i    = bv;
    #1;
    model_edge();
    obs_gnt = gnt_o;
    check("gnt", gnt_o, m_gnt);
    @(posedge cp2);
    #1;
    check("res_vld", res_vld_o, m_vld);
    check("busy", busy_o, m_hi);
    check("res", res_o, m_res);
    check("co", co_o, m_co);
    check("res_id", res_id_o, 64'(m_id));
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 7))
      0: return 32'hFFFF_FFFF;
      1: return 32'h0000_0000;
      2: return 32'h0000_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [NREQ*32-1:0] rnd_ops();
    logic [NREQ*32-1:0] v;
    v = '0;
    for (int i = 0; i < NREQ; i++) v[i*32 +: 32] = rnd32();
    return v;
  endfunction

  logic [NREQ*32-1:0] av, bv;
  logic [NREQ-1:0]    rq, arb_exp [6];

  initial begin
    model_reset();
    // Reset state
    repeat (2) @(posedge cp2);
    #1;
    check("rst_gnt", gnt_o, 0);
    check("rst_res", res_o, 0);
    check("rst_co", co_o, 0);
    check("rst_vld", res_vld_o, 0);
    check("rst_id", res_id_o, 0);
    check("rst_busy", busy_o, 0);
    ireset = 1'b0;
    step('0, '0, '0, '0, '0);
    check("idle_gnt", obs_gnt, 0);

    // Asynchronous reset asserted in the middle of a cycle
    av = '0; bv = '0;
    av[31:0] = 32'h1; bv[31:0] = 32'h2;
    step(3'b001, '0, '0, av, bv);
    check("pre_rst_res", res_o, 32'h3);
    req_i = 3'b001;
    #2;
    ireset = 1'b1;
    #1;
    check("async_gnt", gnt_o, 0);
    check("async_res", res_o, 0);
    check("async_vld", res_vld_o, 0);
    check("async_id", res_id_o, 0);
    model_reset();
    req_i = '0;
    @(negedge cp2);
    ireset = 1'b0;
    @(posedge cp2);
    #1;
    check("post_rst_vld", res_vld_o, 0);

    // Arbitration with all requesters held high
    for (int k = 0; k < 6; k++) begin
`ifdef ADD16_ARB_RR_EN
      arb_exp[k] = NREQ'(1) << (k % NREQ);
`else
      arb_exp[k] = NREQ'(1);
`endif
    end
    for (int k = 0; k < 6; k++) begin
      step(3'b111, '0, 3'($urandom), rnd_ops(), rnd_ops());
      check("arb_gnt", obs_gnt, arb_exp[k]);
    end

    // Narrow add with a 16-bit wrap
    av = '0; bv = '0;
    av[31:0] = 32'h0000_FFFF; bv[31:0] = 32'h1;
    step(3'b001, '0, '0, av, bv);
    check("nw_gnt", obs_gnt, 3'b001);
    check("nw_vld", res_vld_o, 1);
    check("nw_res", res_o, 32'h0);
    check("nw_co", co_o, 1);
    check("nw_id", res_id_o, 0);

    // Wide add with a carry from the low half into the high half
    av = '0; bv = '0;
    av[63:32] = 32'h0000_FFFF; bv[63:32] = 32'h1;
    step(3'b010, 3'b010, '0, av, bv);
    check("wd_gnt", obs_gnt, 3'b010);
    check("wd_busy", busy_o, 1);
    check("wd_vld0", res_vld_o, 0);
    step('0, '0, '0, '0, '0);
    check("wd_vld", res_vld_o, 1);
    check("wd_res", res_o, 32'h0001_0000);
    check("wd_co", co_o, 0);
    check("wd_id", res_id_o, 1);
    check("wd_busy0", busy_o, 0);

    // Wide add that wraps the full 32 bits
    av = '0; bv = '0;
    av[31:0] = 32'hFFFF_FFFF;
    step(3'b001, 3'b001, 3'b001, av, bv);
    step('0, '0, '0, '0, '0);
    check("wf_res", res_o, 32'h0);
    check("wf_co", co_o, 1);
    check("wf_vld", res_vld_o, 1);

    // A request arriving during HI waits and is granted in the result cycle
    step(3'b010, 3'b010, '0, rnd_ops(), rnd_ops());
    step(3'b100, '0, '0, rnd_ops(), rnd_ops());
    check("hi_nogrant", obs_gnt, 0);
    check("hi_vld", res_vld_o, 1);
    step(3'b100, '0, '0, rnd_ops(), rnd_ops());
    check("hi_late_gnt", obs_gnt, 3'b100);

    // Reset one cycle after a wide grant discards the pending result
    step(3'b010, 3'b010, '0, rnd_ops(), rnd_ops());
    check("rh_busy", busy_o, 1);
    req_i  = '0;
    ireset = 1'b1;
    #1;
    check("rh_busy0", busy_o, 0);
    check("rh_vld0", res_vld_o, 0);
    model_reset();
    @(negedge cp2);
    ireset = 1'b0;
    @(posedge cp2);
    #1;
    check("rh_vld", res_vld_o, 0);
    check("rh_busy1", busy_o, 0);
    step(3'b111, '0, '0, rnd_ops(), rnd_ops());
    check("rh_ptr_gnt", obs_gnt, 3'b001);

    // Random traffic: requests are held until granted and are occasionally dropped
    rq = '0;
    for (int n = 0; n < 1500; n++) begin
      rq = rq & ~m_gnt;
      if ($urandom_range(0, 19) == 0) rq = rq & NREQ'($urandom);
      rq = rq | (NREQ'($urandom) & NREQ'($urandom));
      step(rq, NREQ'($urandom), NREQ'($urandom), rnd_ops(), rnd_ops());
    end
    step('0, '0, '0, '0, '0);
    step('0, '0, '0, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
